monitor_link_master: RTL and testbench
======================================

# monitor_link_master

Clocked SPI master that drives the far end of the Pixy 68000 bus-monitor link. Each frame it clocks out a 16-bit control word (input signals, UART byte toward the target, flow-control flags) and clocks in the 56-bit bus snapshot (address, data, output signals, UART byte from the target, flags). It sits in the host-side FPGA or bridge, between the monitor's SPI pins and the host UART/console logic.

## Interface
Parameters:
- CLK_DIV, 4: SPICLK half-period in MCLK_IN cycles; legal range is 2 to 255.
- POLL_GAP, 16: number of MCLK_IN cycles SPISS stays high between auto-polled frames.

Ports:
- MCLK_IN  in  1  system clock; all logic runs on its rising edge.
- RUN_IN  in  1  asynchronous active-low reset.
- START_IN  in  1  one-cycle request to run a single frame; used only when auto-poll is compiled out.
- SPICLK  out  1  SPI clock, MODE1 (CPOL=0, CPHA=1).
- SPISS  out  1  slave select, active low.
- SPISI  out  1  MOSI, LSB first.
- SPISO_IN  in  1  MISO, LSB first.
- INPUT_SIGNAL_IN  in  4  value sent in control bits [3:0].
- HOST_TX_VALID_IN  in  1  host offers a byte for the target.
- HOST_TX_BYTE_IN  in  8  the offered byte.
- HOST_TX_READY  out  1  the pending-byte register is empty.
- HOST_RX_ACK_IN  in  1  host consumes HOST_RX_BYTE.
- HOST_RX_VALID  out  1  HOST_RX_BYTE holds an unconsumed byte.
- HOST_RX_BYTE  out  8  byte received from the target.
- RX_OVERRUN  out  1  one-cycle pulse when a target byte is dropped.
- ADDR  out  24  snapshot bits [23:0].
- DATA  out  16  snapshot bits [39:24].
- OUTPUT_SIGNAL  out  4  snapshot bits [43:40].
- TARGET_RECV_BUSY  out  1  snapshot bit [45].
- FRAME_DONE  out  1  one-cycle strobe when the snapshot outputs update.

## Operation
- MISO frame, 56 bits, LSB first:
  - [23:0] ADDR, [39:24] DATA, [43:40] OUTPUT_SIGNAL.
  - [44] SEND_DATA, [45] RECV_BUSY, [47:46] are 0.
  - [55:48] UART byte from the target.
- MOSI word, 16 bits, LSB first, then 0 for the remaining 40 bits:
  - [3:0] INPUT_SIGNAL_IN, [4] RECEIVE_DATA, [5] SEND_BUSY, [7:6] are 0.
  - [15:8] pending TX byte, or 0 when RECEIVE_DATA=0.
- State machine IDLE → SETUP → SHIFT → HOLD → GAP → IDLE:
  - IDLE: leaves when a frame request is present.
  - SETUP: SPISS goes low; the 16-bit word is latched.
  - SHIFT: 56 SPICLK periods.
  - HOLD: FRAME_DONE is issued.
  - GAP: runs POLL_GAP cycles with auto-poll, 0 cycles without.
- Word latch at SETUP:
  - SEND_BUSY = HOST_RX_VALID.
  - RECEIVE_DATA = 1 when all three hold: a byte is pending, the last TARGET_RECV_BUSY=0, and the previous frame did not carry a byte.
- TX pending register:
  - Loaded when HOST_TX_VALID_IN && HOST_TX_READY.
  - Cleared at FRAME_DONE of the frame that carried it.
  - HOST_TX_READY=0 while the register is full.
- RX path, acting at FRAME_DONE when SEND_DATA=1:
  - HOST_RX_VALID=0: capture the byte into HOST_RX_BYTE and set HOST_RX_VALID.
  - HOST_RX_VALID=1: drop the byte and pulse RX_OVERRUN.
  - If HOST_RX_ACK_IN arrives in the same cycle, the ack clears first, then the capture applies.
- HOST_RX_VALID clears on HOST_RX_ACK_IN.

## Timing
- Reset values:
  - SPICLK=0, SPISS=1, SPISI=0.
  - HOST_TX_READY=1.
  - HOST_RX_VALID=0, HOST_RX_BYTE=0, RX_OVERRUN=0, FRAME_DONE=0.
  - ADDR, DATA, OUTPUT_SIGNAL and TARGET_RECV_BUSY all 0.
  - TX pending register empty.
- SETUP: SPISS low for CLK_DIV cycles before the first SPICLK rise.
- Each bit period is CLK_DIV cycles high followed by CLK_DIV cycles low.
- MOSI bit i changes on the same MCLK edge as SPICLK rise i+1.
- SPISO_IN is sampled on the MCLK edge that drives SPICLK fall n, giving MISO bit n-1.
- FRAME_DONE is issued one cycle after fall 56:
  - Snapshot outputs update on that same cycle.
  - SPISS returns high CLK_DIV cycles later, with SPICLK=0.
- Frame length is 112·CLK_DIV + 2·CLK_DIV + 1 cycles, plus the gap.
- RUN_IN low mid-frame: all outputs return to reset values immediately, and the pending TX byte is discarded.
- Without auto-poll, a START_IN that arrives during a frame is ignored.

## Configuration
- MONITOR_LINK_AUTOPOLL_EN defined: frames repeat forever after reset with POLL_GAP idle between them; START_IN is unused.
- Macro undefined: one frame runs per START_IN pulse accepted in IDLE, and GAP is skipped.

## Test plan
- CLK_DIV=2, slave model returns ADDR=0xABCDEF, DATA=0x1234, OUTPUT_SIGNAL=0x5, SEND_DATA=0 → FRAME_DONE one cycle after fall 56; ADDR/DATA/OUTPUT_SIGNAL match; HOST_RX_VALID stays 0.
- INPUT_SIGNAL_IN=0xA, host offers 0x5A, RECV_BUSY=0 → slave receives MOSI word 0x5A1A; HOST_TX_READY returns high after FRAME_DONE; the next frame carries RECEIVE_DATA=0.
- Slave sends SEND_DATA=1 with byte 0xC3 for two frames, no ack → HOST_RX_BYTE=0xC3; second frame shows SEND_BUSY=1 in MOSI bit 5 and pulses RX_OVERRUN.
- RECV_BUSY=1 in the previous frame with 0x77 pending → RECEIVE_DATA=0 and byte field 0; 0x77 is sent in the first frame after RECV_BUSY=0.
- RUN_IN low at bit 30 → SPISS=1 and SPICLK=0 the same cycle; FRAME_DONE never fires; HOST_TX_READY=1.

Source files
------------

// File: rtl/monitor_link_master.sv
// monitor_link_master: SPI MODE1 master for the 68000 bus-monitor link; define MONITOR_LINK_AUTOPOLL_EN for free-running polling
module monitor_link_master #(
  parameter int CLK_DIV  = 4,
  parameter int POLL_GAP = 16
) (
  input  logic        MCLK_IN,
  input  logic        RUN_IN,
  input  logic        START_IN,
  output logic        SPICLK,
  output logic        SPISS,
  output logic        SPISI,
  input  logic        SPISO_IN,
  input  logic [3:0]  INPUT_SIGNAL_IN,
  input  logic        HOST_TX_VALID_IN,
  input  logic [7:0]  HOST_TX_BYTE_IN,
  output logic        HOST_TX_READY,
  input  logic        HOST_RX_ACK_IN,
  output logic        HOST_RX_VALID,
  output logic [7:0]  HOST_RX_BYTE,
  output logic        RX_OVERRUN,
  output logic [23:0] ADDR,
  output logic [15:0] DATA,
  output logic [3:0]  OUTPUT_SIGNAL,
  output logic        TARGET_RECV_BUSY,
  output logic        FRAME_DONE
);
`ifdef MONITOR_LINK_AUTOPOLL_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int GAP_LEN = AUTO ? POLL_GAP : 0;
  localparam logic [15:0] HALF     = 16'(CLK_DIV - 1);
  localparam logic [15:0] DESEL    = 16'(CLK_DIV);
  localparam logic [15:0] HOLD_END = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] GAP_END  = 16'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [15:0] cnt;
  logic [5:0]  bitn;
  logic [15:0] tx_sr;
  logic [55:0] rx_sr;
  logic [7:0]  tx_byte;
  logic        tx_full, carry, prev_carry;
  logic        req, half_end, rise, fall, start, done_now, rd, unused_bits;

  assign req         = AUTO | START_IN;
  assign half_end    = cnt == HALF;
  assign rise        = half_end && (state == SETUP || (state == SHIFT && !SPICLK));
  assign fall        = half_end && state == SHIFT && SPICLK;
  assign start       = state == IDLE && req;
  assign done_now    = state == HOLD && cnt == 16'd0;
  assign rd          = tx_full && !TARGET_RECV_BUSY && !prev_carry;
  assign unused_bits = ^rx_sr[47:46];
  assign HOST_TX_READY = !tx_full;

  // frame sequencing: select, shift 56 bits, report, deselect, optional gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req ? SETUP : IDLE;
      SETUP:   state_nxt = half_end ? SHIFT : SETUP;
      SHIFT:   state_nxt = (fall && bitn == 6'd55) ? HOLD : SHIFT;
      HOLD:    state_nxt = cnt == HOLD_END ? (GAP_LEN == 0 ? IDLE : GAP) : HOLD;
      GAP:     state_nxt = cnt == GAP_END ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge MCLK_IN or negedge RUN_IN)
    if (!RUN_IN) state <= IDLE;
    else state <= state_nxt;

  // cycle counter restarts on every state change and every SPICLK half-period
  always_ff @(posedge MCLK_IN or negedge RUN_IN)
    if (!RUN_IN) cnt <= '0;
    else cnt <= (state == IDLE || state_nxt != state || (state == SHIFT && half_end)) ? '0 : cnt + 16'd1;

  // SPI pins: MOSI moves on rises, MISO is sampled on falls
  always_ff @(posedge MCLK_IN or negedge RUN_IN)
    if (!RUN_IN) begin
      SPICLK <= 1'b0;
      SPISS  <= 1'b1;
      SPISI  <= 1'b0;
      bitn   <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      carry  <= 1'b0;
    end else begin
      if (start) begin
        SPISS <= 1'b0;
        bitn  <= '0;
        carry <= rd;
        tx_sr <= {rd ? tx_byte : 8'h00, 2'b00, HOST_RX_VALID, rd, INPUT_SIGNAL_IN};
      end
      if (rise) begin
        SPICLK <= 1'b1;
        SPISI  <= tx_sr[0];
        tx_sr  <= {1'b0, tx_sr[15:1]};
      end
      if (fall) begin
        SPICLK <= 1'b0;
        rx_sr  <= {SPISO_IN, rx_sr[55:1]};
        bitn   <= bitn + 6'd1;
      end
      if (state == HOLD && cnt == DESEL) SPISS <= 1'b1;
    end

  // snapshot publish plus host-side TX/RX byte handshakes
  always_ff @(posedge MCLK_IN or negedge RUN_IN)
    if (!RUN_IN) begin
      FRAME_DONE       <= 1'b0;
      RX_OVERRUN       <= 1'b0;
      ADDR             <= '0;
      DATA             <= '0;
      OUTPUT_SIGNAL    <= '0;
      TARGET_RECV_BUSY <= 1'b0;
      prev_carry       <= 1'b0;
      HOST_RX_VALID    <= 1'b0;
      HOST_RX_BYTE     <= '0;
      tx_full          <= 1'b0;
      tx_byte          <= '0;
    end else begin
      FRAME_DONE <= done_now;
      RX_OVERRUN <= done_now && rx_sr[44] && HOST_RX_VALID && !HOST_RX_ACK_IN;
      if (done_now) begin
        ADDR             <= rx_sr[23:0];
        DATA             <= rx_sr[39:24];
        OUTPUT_SIGNAL    <= rx_sr[43:40];
        TARGET_RECV_BUSY <= rx_sr[45];
        prev_carry       <= carry;
      end
      if (done_now && rx_sr[44] && (!HOST_RX_VALID || HOST_RX_ACK_IN)) begin
        HOST_RX_VALID <= 1'b1;
        HOST_RX_BYTE  <= rx_sr[55:48];
      end else if (HOST_RX_ACK_IN) HOST_RX_VALID <= 1'b0;
      if (done_now && carry) tx_full <= 1'b0;
      else if (HOST_TX_VALID_IN && !tx_full) begin
        tx_full <= 1'b1;
        tx_byte <= HOST_TX_BYTE_IN;
      end
    end
endmodule

// File: tb/tb_monitor_link_master.sv
// tb_monitor_link_master: scoreboard bench with an SPI slave model for monitor_link_master
module tb_monitor_link_master;
  localparam int D = 2;

  logic MCLK_IN = 1'b0, RUN_IN = 1'b0, START_IN = 1'b0, SPISO_IN = 1'b0;
  logic HOST_TX_VALID_IN = 1'b0, HOST_RX_ACK_IN = 1'b0;
  logic [3:0] INPUT_SIGNAL_IN = 4'h0;
  logic [7:0] HOST_TX_BYTE_IN = 8'h00;
  logic SPICLK, SPISS, SPISI, HOST_TX_READY, HOST_RX_VALID, RX_OVERRUN, TARGET_RECV_BUSY, FRAME_DONE;
  logic [7:0] HOST_RX_BYTE;
  logic [23:0] ADDR;
  logic [15:0] DATA;
  logic [3:0] OUTPUT_SIGNAL;

  monitor_link_master #(.CLK_DIV(D), .POLL_GAP(16)) dut (
    .MCLK_IN(MCLK_IN), .RUN_IN(RUN_IN), .START_IN(START_IN),
    .SPICLK(SPICLK), .SPISS(SPISS), .SPISI(SPISI), .SPISO_IN(SPISO_IN),
    .INPUT_SIGNAL_IN(INPUT_SIGNAL_IN), .HOST_TX_VALID_IN(HOST_TX_VALID_IN),
    .HOST_TX_BYTE_IN(HOST_TX_BYTE_IN), .HOST_TX_READY(HOST_TX_READY),
    .HOST_RX_ACK_IN(HOST_RX_ACK_IN), .HOST_RX_VALID(HOST_RX_VALID),
    .HOST_RX_BYTE(HOST_RX_BYTE), .RX_OVERRUN(RX_OVERRUN), .ADDR(ADDR), .DATA(DATA),
    .OUTPUT_SIGNAL(OUTPUT_SIGNAL), .TARGET_RECV_BUSY(TARGET_RECV_BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 MCLK_IN = ~MCLK_IN;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic [3:0]  osig;
    logic        busy;
    logic [15:0] mosi;
    logic        rxv;
    logic [7:0]  rxb;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int vectors = 0, miscompares = 0, frames = 0;
  int cyc = 0, sk = 0, rk = 0, ss_cyc = 0, fall_cyc = 0;
  logic [55:0] slave_word = '0, mosi_cap = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] sw(input logic [23:0] a, input logic [15:0] d, input logic [3:0] o,
                                     input logic s, input logic b, input logic [7:0] y);
    return {y, 2'b00, b, s, o, d, a};
  endfunction

  function automatic exp_t ex(input logic [23:0] a, input logic [15:0] d, input logic [3:0] o, input logic b,
                              input logic [15:0] m, input logic v, input logic [7:0] y, input logic ov);
    return '{addr: a, data: d, osig: o, busy: b, mosi: m, rxv: v, rxb: y, ovr: ov};
  endfunction

  always @(posedge MCLK_IN) cyc++;

  // slave model: MISO changes on SPICLK rise, MOSI captured on SPICLK fall
  always @(negedge SPISS) begin
    sk = 0;
    rk = 0;
    mosi_cap = '0;
    ss_cyc = cyc;
  end

  always @(posedge SPICLK) begin
    if (sk == 0) check("setup_len", 64'(cyc - ss_cyc), 64'(D));
    if (sk < 56) SPISO_IN = slave_word[sk];
    sk++;
  end

  always @(negedge SPICLK) begin
    if (rk < 56) mosi_cap[rk] = SPISI;
    rk++;
    fall_cyc = cyc;
  end

  // scoreboard pop on every FRAME_DONE
  always @(negedge MCLK_IN)
    if (FRAME_DONE) begin
      frames++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_lat", 64'(cyc - fall_cyc), 1);
        check("addr", ADDR, e.addr);
        check("data", DATA, e.data);
        check("osig", OUTPUT_SIGNAL, e.osig);
        check("recv_busy", TARGET_RECV_BUSY, e.busy);
        check("mosi_word", mosi_cap[15:0], e.mosi);
        check("mosi_tail", mosi_cap[55:16], 0);
        check("rx_valid", HOST_RX_VALID, e.rxv);
        check("rx_byte", HOST_RX_BYTE, e.rxb);
        check("rx_overrun", RX_OVERRUN, e.ovr);
      end
    end

  task automatic run_frame(input logic [55:0] w, input exp_t x);
    int n;
    slave_word = w;
    sb.push_back(x);
    @(negedge MCLK_IN) START_IN = 1'b1;
    @(negedge MCLK_IN) START_IN = 1'b0;
    repeat (20) @(negedge MCLK_IN);
    START_IN = 1'b1;
    @(negedge MCLK_IN) START_IN = 1'b0;
    n = 0;
    while (!FRAME_DONE && n < 400) begin
      @(posedge MCLK_IN);
      #1 n++;
    end
    if (n >= 400) begin
      check("frame_timeout", 0, 1);
      sb.delete();
      return;
    end
    repeat (D - 1) @(posedge MCLK_IN);
    #1 check("ss_hold", SPISS, 0);
    @(posedge MCLK_IN);
    #1 check("ss_release", {SPISS, SPICLK}, 2'b10);
    repeat (D + 4) @(posedge MCLK_IN);
    #1 check("idle_after", SPISS, 1);
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge MCLK_IN);
    HOST_TX_VALID_IN = 1'b1;
    HOST_TX_BYTE_IN = b;
    @(negedge MCLK_IN) HOST_TX_VALID_IN = 1'b0;
    check("tx_ready_low", HOST_TX_READY, 0);
  endtask

  initial begin
    int n, f0;
    repeat (3) @(posedge MCLK_IN);
    #1;
    check("rst_spi", {SPICLK, SPISS, SPISI}, 3'b010);
    check("rst_host", {HOST_TX_READY, HOST_RX_VALID, HOST_RX_BYTE, RX_OVERRUN, FRAME_DONE}, {1'b1, 1'b0, 8'h00, 2'b00});
    check("rst_snap", {ADDR, DATA, OUTPUT_SIGNAL, TARGET_RECV_BUSY}, 0);
    @(negedge MCLK_IN) RUN_IN = 1'b1;
    run_frame(sw(24'hABCDEF, 16'h1234, 4'h5, 1'b0, 1'b0, 8'h00),
              ex(24'hABCDEF, 16'h1234, 4'h5, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
    INPUT_SIGNAL_IN = 4'hA;
    offer(8'h5A);
    run_frame(sw(24'h000001, 16'hFFFF, 4'hA, 1'b0, 1'b0, 8'h00),
              ex(24'h000001, 16'hFFFF, 4'hA, 1'b0, 16'h5A1A, 1'b0, 8'h00, 1'b0));
    check("tx_ready_back", HOST_TX_READY, 1);
    run_frame(sw(24'h123456, 16'h0000, 4'h0, 1'b1, 1'b0, 8'hC3),
              ex(24'h123456, 16'h0000, 4'h0, 1'b0, 16'h000A, 1'b1, 8'hC3, 1'b0));
    run_frame(sw(24'h654321, 16'hBEEF, 4'h3, 1'b1, 1'b1, 8'hC3),
              ex(24'h654321, 16'hBEEF, 4'h3, 1'b1, 16'h002A, 1'b1, 8'hC3, 1'b1));
    check("ovr_pulse_end", RX_OVERRUN, 0);
    @(negedge MCLK_IN) HOST_RX_ACK_IN = 1'b1;
    @(negedge MCLK_IN) HOST_RX_ACK_IN = 1'b0;
    check("rx_ack", HOST_RX_VALID, 0);
    offer(8'h77);
    run_frame(sw(24'h000000, 16'h0000, 4'h0, 1'b0, 1'b0, 8'h00),
              ex(24'h000000, 16'h0000, 4'h0, 1'b0, 16'h000A, 1'b0, 8'hC3, 1'b0));
    check("tx_held", HOST_TX_READY, 0);
    run_frame(sw(24'hFFFFFF, 16'h5555, 4'hF, 1'b0, 1'b0, 8'h00),
              ex(24'hFFFFFF, 16'h5555, 4'hF, 1'b0, 16'h771A, 1'b0, 8'hC3, 1'b0));
    check("tx_sent", HOST_TX_READY, 1);
    offer(8'h99);
    slave_word = sw(24'h111111, 16'h2222, 4'h3, 1'b1, 1'b0, 8'h44);
    @(negedge MCLK_IN) START_IN = 1'b1;
    @(negedge MCLK_IN) START_IN = 1'b0;
    n = 0;
    while (sk < 30 && n < 300) begin
      @(negedge MCLK_IN);
      n++;
    end
    check("bit30_reached", sk >= 30, 1);
    #2 RUN_IN = 1'b0;
    #1;
    check("rst_mid_spi", {SPISS, SPICLK, FRAME_DONE}, 3'b100);
    check("rst_mid_ready", HOST_TX_READY, 1);
    f0 = frames;
    @(negedge MCLK_IN) RUN_IN = 1'b1;
    repeat (400) @(posedge MCLK_IN);
    check("no_done_after_abort", frames, f0);
    run_frame(sw(24'h0A0B0C, 16'h0D0E, 4'h1, 1'b0, 1'b0, 8'h00),
              ex(24'h0A0B0C, 16'h0D0E, 4'h1, 1'b0, 16'h000A, 1'b0, 8'h00, 1'b0));
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
